clk_monitor: RTL and testbench
==============================

# clk_monitor

Measures a slow clock or strobe against the 50 MHz system clock, the receiving end of the clock-divider outputs. It synchronises an asynchronous `clk_in` into the `clk_50m` domain and detects its rising edges. It reports each period in `clk_50m` cycles and raises lock/loss status against an expected period. It sits beside the divider to supervise `clk_100k` (scan clock) or any external reference before downstream logic trusts it.

## Interface
- `EXP_PERIOD`, 500, expected period in `clk_50m` cycles (500 = 100 kHz)
- `TOL`, 2, allowed absolute deviation from `EXP_PERIOD`, inclusive
- `LOCK_CNT`, 4, consecutive in-tolerance periods required to lock
- `TIMEOUT`, 1000, cycles without a rise before timeout; must exceed `EXP_PERIOD+TOL` and fit in `CNT_W`
- `CNT_W`, 16, width of the counters and the measured values
- `clk_50m` in 1: system clock, the only clock
- `rst_n` in 1: synchronous, active-low reset
- `clk_in` in 1: monitored signal, asynchronous to `clk_50m`
- `edge_pulse` out 1: one-cycle pulse per detected rising edge of `clk_in`
- `period` out `CNT_W`: last measured period
- `period_vld` out 1: one-cycle pulse when `period` updates
- `high_time` out `CNT_W`: last measured high time; constant 0 without `CLK_MON_DUTY_EN`
- `locked` out 1: high only in LOCKED
- `lost` out 1: sticky loss flag

## Operation
- Three-flop chain s1→s2→s3 on `clk_in`. Internal `rise` = s2 & ~s3; internal `fall` = ~s2 & s3.
- Period counter `cnt`:
  - loads 1 on `rise`;
  - otherwise increments;
  - holds at `TIMEOUT`.
- On `rise`:
  - `edge_pulse` is set to 1.
  - If a valid reference edge exists, then `period` is set to `cnt` and `period_vld` is set to 1.
  - A period is "good" when |`period` − `EXP_PERIOD`| ≤ `TOL`.
- A valid reference edge exists after any rise, except in IDLE. A timeout discards the reference.
- FSM states: IDLE, MEASURE, LOCKED, LOST.
  - IDLE: on `rise`, go to MEASURE with `good_cnt` = 0. No `period_vld` is produced.
  - MEASURE, good `rise`: `good_cnt`++. When it reaches `LOCK_CNT`, go to LOCKED, `locked` goes to 1 and `lost` goes to 0.
  - MEASURE, bad `rise`: `good_cnt` = 0.
  - MEASURE, `cnt` == `TIMEOUT`: go to IDLE.
  - LOCKED, bad `rise` or `cnt` == `TIMEOUT`: go to LOST and set `lost` to 1. On timeout the reference is discarded.
  - LOST, `rise`: go to MEASURE with `good_cnt` = 0. `period_vld` is produced only if the reference is valid. This period is not counted toward lock.
  - LOST with no rise: remain in LOST.
- Simultaneous `rise` and `cnt` == `TIMEOUT`: the rise wins. The period is reported as `TIMEOUT`, which is always bad.
- Reset values:
  - all outputs 0;
  - s1/s2/s3 = 0;
  - `cnt` = 0;
  - `good_cnt` = 0;
  - state IDLE.
- `clk_in` already high at reset release produces one spurious `rise`, used only as the IDLE reference. The next period is then short and bad, which delays lock by one period. No other effect.
- Reset mid-operation takes effect on the next `clk_50m` edge. All state is discarded.

## Timing
- `clk_in` first sampled high at edge n: s2 = 1 after n+1, and `edge_pulse`/`period_vld`/`period` are valid after edge n+2.
- Latency is 2–3 cycles from the asynchronous edge to `edge_pulse`. It is constant for the relative timing of consecutive edges.
- `locked` and `lost` update on the same edge as the `period_vld` that causes the change.
- On timeout, the state changes on the edge after `cnt` reaches `TIMEOUT`.
- All outputs are registered. No combinational path exists from `clk_in`.

## Configuration
- `CLK_MON_DUTY_EN` defined:
  - counter `hcnt` loads 1 on `rise`;
  - it increments while s2 = 1 and saturates at all-ones;
  - on `fall`, `high_time` is set to `hcnt`.
  - `fall` before the first `rise` after reset or timeout is ignored.
- `CLK_MON_DUTY_EN` undefined: no high-time logic is built, and `high_time` is tied to 0.

## Test plan
- Clean 100 kHz, 50 % duty, defaults:
  - first rise: `edge_pulse` only;
  - each later rise: `period_vld` with `period` = 500;
  - `locked` = 1 on the edge of the 5th rise's `period_vld`.
- Locked, then `clk_in` held low: `locked` falls and `lost` = 1 exactly `TIMEOUT` cycles after the last `rise` plus one edge. The next rise gives no `period_vld`. Lock returns after 5 more good rises with `lost` cleared.
- Locked, one period of 503 cycles: `period` = 503, LOST, `locked` = 0, `lost` = 1. Four subsequent 500-cycle periods after re-entering MEASURE relock.
- Period 498 and 502 alternating: stays good, and lock is reached on schedule. Period 497: `good_cnt` resets, and lock is delayed by one window.
- `CLK_MON_DUTY_EN` with 150 high / 350 low: `high_time` = 150 after each fall, and `period` = 500. Without the macro, `high_time` stays 0.
- `rst_n` low for 1 cycle mid-lock with `clk_in` high:
  - all outputs 0 on the next edge;
  - a spurious rise is taken as reference;
  - the first `period` is < 500 and bad;
  - lock is reached on the 6th subsequent rise.

Source files
------------

// File: rtl/clk_monitor.sv
// ---------------------------------------------------------------------------
// clk_monitor
//   Supervises a slow clock or strobe (clk_in) against the 50 MHz system
//   clock. clk_in is synchronised into the clk_50m domain, its rising edges
//   are detected, each rise-to-rise period is measured in clk_50m cycles and
//   lock / loss status is derived against an expected period.
//
//   Optional feature macro: CLK_MON_DUTY_EN
//     defined   : high time of clk_in is measured and reported on high_time
//     undefined : no high-time logic, high_time is tied to zero
//
// Ports
//   clk_50m    in  : system clock, the only clock
//   rst_n      in  : synchronous active-low reset
//   clk_in     in  : monitored signal, asynchronous to clk_50m
//   edge_pulse out : one-cycle pulse per detected rising edge of clk_in
//   period     out : last measured period (clk_50m cycles)
//   period_vld out : one-cycle pulse when period updates
//   high_time  out : last measured high time (0 without CLK_MON_DUTY_EN)
//   locked     out : high only while locked
//   lost       out : sticky loss flag, cleared when lock is regained
// ---------------------------------------------------------------------------
module clk_monitor #(
   parameter int unsigned EXP_PERIOD = 500,
   parameter int unsigned TOL        = 2,
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned TIMEOUT    = 1000,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_50m,
   input  logic             rst_n,
   input  logic             clk_in,
   output logic             edge_pulse,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic [CNT_W-1:0] high_time,
   output logic             locked,
   output logic             lost
);

   localparam int unsigned      GC_W      = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] GOOD_LO   = CNT_W'(EXP_PERIOD - TOL);
   localparam logic [CNT_W-1:0] GOOD_HI   = CNT_W'(EXP_PERIOD + TOL);
   localparam logic [GC_W-1:0]  GC_LAST   = GC_W'(LOCK_CNT - 1);

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED,
      LOST
   } state_t;

   state_t           state;
   logic             s1, s2, s3;
   logic [CNT_W-1:0] cnt;
   logic [GC_W-1:0]  good_cnt;
   logic             ref_vld;
   logic             rise;
   logic             timeout;
   logic             good;

   // s1 is the metastability flop; edges are detected on s2/s3
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= clk_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_comb begin
      rise    = s2 & ~s3;
      // a rise coinciding with saturation wins over the timeout
      timeout = (cnt == TIMEOUT_C) & ~rise;
      // cnt equals the period being reported on this rise
      good    = (cnt >= GOOD_LO) && (cnt <= GOOD_HI);
   end

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         good_cnt   <= '0;
         ref_vld    <= 1'b0;
         edge_pulse <= 1'b0;
         period     <= '0;
         period_vld <= 1'b0;
         locked     <= 1'b0;
         lost       <= 1'b0;
      end else begin
         edge_pulse <= rise;
         period_vld <= 1'b0;

         if (rise) begin
            cnt <= CNT_W'(1);
         end else if (cnt != TIMEOUT_C) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (rise) begin
            ref_vld <= 1'b1;
         end else if (timeout) begin
            ref_vld <= 1'b0;
         end

         if (rise && (state != IDLE) && ref_vld) begin
            period     <= cnt;
            period_vld <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (rise) begin
                  state    <= MEASURE;
                  good_cnt <= '0;
               end
            end
            MEASURE: begin
               if (rise) begin
                  if (good) begin
                     if (good_cnt == GC_LAST) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        lost     <= 1'b0;
                        good_cnt <= '0;
                     end else begin
                        good_cnt <= good_cnt + GC_W'(1);
                     end
                  end else begin
                     good_cnt <= '0;
                  end
               end else if (timeout) begin
                  state <= IDLE;
               end
            end
            LOCKED: begin
               if ((rise && !good) || timeout) begin
                  state  <= LOST;
                  locked <= 1'b0;
                  lost   <= 1'b1;
               end
            end
            LOST: begin
               // the period ending on this rise never counts toward lock
               if (rise) begin
                  state    <= MEASURE;
                  good_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CLK_MON_DUTY_EN
   logic             fall;
   logic [CNT_W-1:0] hcnt;
   logic             h_arm;

   always_comb begin
      fall = ~s2 & s3;
   end

   // h_arm blocks a fall that has no preceding rise since reset/timeout
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         hcnt      <= '0;
         h_arm     <= 1'b0;
         high_time <= '0;
      end else begin
         if (rise) begin
            hcnt <= CNT_W'(1);
         end else if (s2 && (hcnt != '1)) begin
            hcnt <= hcnt + CNT_W'(1);
         end

         if (rise) begin
            h_arm <= 1'b1;
         end else if (timeout) begin
            h_arm <= 1'b0;
         end

         if (fall && h_arm) begin
            high_time <= hcnt;
         end
      end
   end
`else
   always_comb begin
      high_time = '0;
   end
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_monitor
//   Self-checking bench for clk_monitor. clk_in is driven one clk_50m cycle
//   grid at a time, so every period and high time is an exact cycle count.
//   An event-level reference model predicts the outputs at each rise.
// ---------------------------------------------------------------------------
module tb_clk_monitor;

   localparam int EXP   = 500;
   localparam int TOL   = 2;
   localparam int LOCKN = 4;
   localparam int TMO   = 1000;
   localparam int W     = 16;

   logic         clk_50m = 1'b0;
   logic         rst_n   = 1'b0;
   logic         clk_in  = 1'b0;
   logic         edge_pulse;
   logic [W-1:0] period;
   logic         period_vld;
   logic [W-1:0] high_time;
   logic         locked;
   logic         lost;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   clk_monitor #(
      .EXP_PERIOD (EXP),
      .TOL        (TOL),
      .LOCK_CNT   (LOCKN),
      .TIMEOUT    (TMO),
      .CNT_W      (W)
   ) dut (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .clk_in     (clk_in),
      .edge_pulse (edge_pulse),
      .period     (period),
      .period_vld (period_vld),
      .high_time  (high_time),
      .locked     (locked),
      .lost       (lost)
   );

   always #10 clk_50m = ~clk_50m;

   always @(posedge clk_50m) cyc <= cyc + 1;

   // pulse counters and event timestamps, sampled on the falling edge
   int   n_edge     = 0;
   int   n_vld      = 0;
   int   edge_cyc   = 0;
   int   lfall_cyc  = -1;
   logic prev_locked = 1'b0;

   always @(negedge clk_50m) begin
      if (edge_pulse === 1'b1) begin
         n_edge   = n_edge + 1;
         edge_cyc = cyc;
      end
      if (period_vld === 1'b1) n_vld = n_vld + 1;
      if (prev_locked === 1'b1 && locked === 1'b0) lfall_cyc = cyc;
      prev_locked = locked;
   end

   initial begin
      #(20 * 200000);
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
      $fatal(1);
   end

   // ------------------------------------------------------------------
   // Reference model: processes one rise at a time, given the number of
   // cycles since the previous rise.
   // ------------------------------------------------------------------
   bit           m_armed;   // a rise has been seen (not idle)
   bit           m_ref;     // previous rise usable as a reference
   bit           m_locked;
   bit           m_lost;
   bit           m_skip;    // next period is discarded (after a loss)
   int           m_run;     // consecutive good counted periods
   logic [W-1:0] m_period;
   int           exp_edge  = 0;
   int           exp_vld   = 0;
   int           last_up   = 0;
   int           last_hi   = 0;
   int           rise_idx  = 0;
   int           lock_idx  = 0;

   task automatic model_reset();
      m_armed  = 1'b0;
      m_ref    = 1'b0;
      m_locked = 1'b0;
      m_lost   = 1'b0;
      m_skip   = 1'b0;
      m_run    = 0;
      m_period = '0;
      last_up  = cyc - 100000;
      last_hi  = 0;
      rise_idx = 0;
      lock_idx = 0;
   endtask

   task automatic model_rise(input int p, output bit vld);
      bit good;
      if (m_armed && p > TMO) begin
         m_ref = 1'b0;
         if (m_locked) begin
            m_locked = 1'b0;
            m_lost   = 1'b1;
            m_skip   = 1'b1;
         end else if (!m_skip) begin
            m_armed = 1'b0;
         end
      end
      good = (p >= EXP - TOL) && (p <= EXP + TOL);
      vld  = m_armed && m_ref;
      if (vld) m_period = W'(p);
      if (!m_armed) begin
         m_armed = 1'b1;
         m_run   = 0;
      end else if (m_skip) begin
         m_skip = 1'b0;
         m_run  = 0;
      end else if (m_locked) begin
         if (!good) begin
            m_locked = 1'b0;
            m_lost   = 1'b1;
            m_skip   = 1'b1;
         end
      end else if (good) begin
         m_run = m_run + 1;
         if (m_run == LOCKN) begin
            m_locked = 1'b1;
            m_lost   = 1'b0;
         end
      end else begin
         m_run = 0;
      end
      m_ref    = 1'b1;
      exp_edge = exp_edge + 1;
      if (vld) exp_vld = exp_vld + 1;
   endtask

   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   // drive clk_in high for hi cycles; outputs of this rise land 3 ticks on
   task automatic rise_phase(input int hi);
      bit vld;
      int p;
      p       = cyc - last_up;
      last_up = cyc;
      last_hi = hi;
      clk_in  = 1'b1;
      model_rise(p, vld);
      rise_idx = rise_idx + 1;
      for (int i = 1; i <= hi; i++) begin
         tick();
         if (i == 3) begin
            checks++;
            if (edge_pulse !== 1'b1) begin
               failures++;
               $display("FAIL rise_edge_pulse rise=%0d got=%b want=1", rise_idx, edge_pulse);
            end
            checks++;
            if (period_vld !== vld) begin
               failures++;
               $display("FAIL rise_period_vld rise=%0d got=%b want=%b", rise_idx, period_vld, vld);
            end
            checks++;
            if (period !== m_period) begin
               failures++;
               $display("FAIL rise_period rise=%0d got=%0d want=%0d", rise_idx, period, m_period);
            end
            checks++;
            if (locked !== m_locked) begin
               failures++;
               $display("FAIL rise_locked rise=%0d got=%b want=%b", rise_idx, locked, m_locked);
            end
            checks++;
            if (lost !== m_lost) begin
               failures++;
               $display("FAIL rise_lost rise=%0d got=%b want=%b", rise_idx, lost, m_lost);
            end
            if (locked === 1'b1 && lock_idx == 0) lock_idx = rise_idx;
         end
      end
   endtask

   task automatic fall_phase(input int lo);
      logic [W-1:0] want_ht;
`ifdef CLK_MON_DUTY_EN
      want_ht = W'(last_hi);
`else
      want_ht = '0;
`endif
      clk_in = 1'b0;
      for (int i = 1; i <= lo; i++) begin
         tick();
         if (i == 3) begin
            checks++;
            if (high_time !== want_ht) begin
               failures++;
               $display("FAIL fall_high_time rise=%0d got=%0d want=%0d", rise_idx, high_time, want_ht);
            end
            checks++;
            if (edge_pulse !== 1'b0 || period_vld !== 1'b0) begin
               failures++;
               $display("FAIL fall_no_pulse rise=%0d got=%b%b want=00", rise_idx, edge_pulse, period_vld);
            end
         end
      end
   endtask

   task automatic do_reset();
      clk_in = 1'b0;
      rst_n  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_counts(input string name);
      checks++;
      if (n_edge !== exp_edge) begin
         failures++;
         $display("FAIL %s_edge_count got=%0d want=%0d", name, n_edge, exp_edge);
      end
      checks++;
      if (n_vld !== exp_vld) begin
         failures++;
         $display("FAIL %s_vld_count got=%0d want=%0d", name, n_vld, exp_vld);
      end
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      clk_in = 1'b0;
      rst_n  = 1'b0;
      tick();
      tick();
      checks++;
      if ({edge_pulse, period_vld, locked, lost} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=0000", {edge_pulse, period_vld, locked, lost});
      end
      checks++;
      if (period !== '0 || high_time !== '0) begin
         failures++;
         $display("FAIL reset_values got=%0d/%0d want=0/0", period, high_time);
      end
      rst_n = 1'b1;
      model_reset();
      repeat (20) tick();
   endtask

   task automatic test_clean_lock();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         rise_phase(250);
         fall_phase(250);
      end
      checks++;
      if (lock_idx !== 5) begin
         failures++;
         $display("FAIL clean_lock_rise got=%0d want=5", lock_idx);
      end
      check_counts("clean");
   endtask

   // continues from the locked state left by test_clean_lock
   task automatic test_timeout();
      rise_phase(250);
      fall_phase(1200);
      checks++;
      if (lfall_cyc - edge_cyc !== TMO) begin
         failures++;
         $display("FAIL timeout_latency got=%0d want=%0d", lfall_cyc - edge_cyc, TMO);
      end
      checks++;
      if (locked !== 1'b0 || lost !== 1'b1) begin
         failures++;
         $display("FAIL timeout_status got=locked%b/lost%b want=locked0/lost1", locked, lost);
      end
      rise_idx = 0;
      lock_idx = 0;
      for (int i = 0; i < 6; i++) begin
         rise_phase(250);
         fall_phase(250);
      end
      checks++;
      if (lock_idx !== 5 || lost !== 1'b0) begin
         failures++;
         $display("FAIL timeout_relock got=rise%0d/lost%b want=rise5/lost0", lock_idx, lost);
      end
      check_counts("timeout");
   endtask

   // continues from locked
   task automatic test_bad_period();
      rise_phase(250);
      fall_phase(253);
      rise_phase(250);
      checks++;
      if (period !== 16'd503 || locked !== 1'b0 || lost !== 1'b1) begin
         failures++;
         $display("FAIL bad_period got=p%0d/l%b/x%b want=p503/l0/x1", period, locked, lost);
      end
      fall_phase(250);
      rise_idx = 0;
      lock_idx = 0;
      for (int i = 0; i < 6; i++) begin
         rise_phase(250);
         fall_phase(250);
      end
      checks++;
      if (lock_idx !== 5) begin
         failures++;
         $display("FAIL bad_period_relock got=%0d want=5", lock_idx);
      end
      check_counts("bad_period");
   endtask

   task automatic test_tolerance();
      int ps [8];
      do_reset();
      for (int i = 0; i < 6; i++) begin
         rise_phase(249);
         fall_phase((i % 2 == 0) ? 249 : 253);
      end
      checks++;
      if (lock_idx !== 5) begin
         failures++;
         $display("FAIL tol_edges_lock got=%0d want=5", lock_idx);
      end
      ps = '{500, 500, 497, 500, 500, 500, 500, 500};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         rise_phase(250);
         fall_phase(ps[i] - 250);
      end
      rise_phase(250);
      fall_phase(250);
      checks++;
      if (lock_idx !== 8) begin
         failures++;
         $display("FAIL tol_497_lock got=%0d want=8", lock_idx);
      end
      check_counts("tolerance");
   endtask

   task automatic test_timeout_edge();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         rise_phase(250);
         fall_phase(250);
      end
      rise_phase(400);
      fall_phase(600);
      rise_phase(250);
      checks++;
      if (period !== 16'd1000 || lost !== 1'b1 || locked !== 1'b0) begin
         failures++;
         $display("FAIL timeout_edge got=p%0d/l%b/x%b want=p1000/l0/x1", period, locked, lost);
      end
      fall_phase(250);
      check_counts("timeout_edge");
   endtask

   task automatic test_duty();
      logic [W-1:0] want_ht;
`ifdef CLK_MON_DUTY_EN
      want_ht = 16'd150;
`else
      want_ht = '0;
`endif
      do_reset();
      for (int i = 0; i < 6; i++) begin
         rise_phase(150);
         fall_phase(350);
      end
      checks++;
      if (high_time !== want_ht || period !== 16'd500) begin
         failures++;
         $display("FAIL duty got=ht%0d/p%0d want=ht%0d/p500", high_time, period, want_ht);
      end
      check_counts("duty");
   endtask

   task automatic test_reset_midlock();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         rise_phase(250);
         fall_phase(250);
      end
      rise_phase(50);
      rst_n = 1'b0;
      tick();
      checks++;
      if ({edge_pulse, period_vld, locked, lost} !== 4'b0000 || period !== '0 || high_time !== '0) begin
         failures++;
         $display("FAIL midlock_reset got=%b p%0d ht%0d want=0000 p0 ht0",
                  {edge_pulse, period_vld, locked, lost}, period, high_time);
      end
      rst_n = 1'b1;
      model_reset();
      rise_phase(100);
      fall_phase(200);
      for (int i = 0; i < 6; i++) begin
         rise_phase(250);
         fall_phase(250);
      end
      checks++;
      if (lock_idx !== 6) begin
         failures++;
         $display("FAIL midlock_relock got=%0d want=6", lock_idx);
      end
      check_counts("midlock");
   endtask

   task automatic test_random();
      int p;
      int hi;
      int sel;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 5)      p = $urandom_range(EXP - TOL, EXP + TOL);
         else if (sel <= 7) p = $urandom_range(490, 510);
         else if (sel == 8) p = $urandom_range(TMO - 3, TMO + 3);
         else               p = $urandom_range(TMO + 1, 1400);
         hi = $urandom_range(10, ((p < 900) ? p : 900) - 10);
         rise_phase(hi);
         fall_phase(p - hi);
      end
      rise_phase(20);
      fall_phase(20);
      check_counts("random");
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_timeout();
      test_bad_period();
      test_tolerance();
      test_timeout_edge();
      test_duty();
      test_reset_midlock();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
